instr_stream_checker: RTL and testbench

- Synthesizable, parametrised program driver and self-checker for the single-cycle core.
- Holds up to DEPTH instructions, each with an optional expected register writeback.
- Issues the instructions to the core in order, observes the core's register-file write port, and reports pass/fail with the failing index and observed data.
- Sits beside `top` in bring-up builds; replaces hand-timed instruction pokes in benches.

---
 rtl/instr_stream_checker_pkg.sv | 25 ++
 rtl/instr_stream_checker_prog_mem.sv | 28 ++
 rtl/instr_stream_checker.sv | 195 +++++++++++++++++++
 tb/tb_instr_stream_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_checker_pkg.sv
// Shared types for the instruction stream checker: FSM states, program entry
// layout and the register-zero constant.
package instr_chk_pkg;

    // Width of the core the checker drives; program entries are laid out for it.
    localparam int CORE_XLEN = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_WB = 2'd2,
        DONE    = 2'd3
    } chk_state_t;

    // One program slot: the instruction plus its optional expected writeback.
    typedef struct packed {
        logic [CORE_XLEN-1:0] instr;
        logic                 chk;
        logic [4:0]           rd;
        logic [CORE_XLEN-1:0] val;
    } prog_entry_t;

endpackage

// File: rtl/instr_stream_checker_prog_mem.sv
// Program store: DEPTH entries, one synchronous write port and one
// combinational read port. Contents are not reset.
module prog_mem
    import instr_chk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  prog_entry_t   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output prog_entry_t   rdata_o
);

    prog_entry_t mem_q [DEPTH];

    // Write one entry per cycle when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_stream_checker.sv
// Program driver and self-checker for the single-cycle core: issues the stored
// program in order, watches the register-file write port and reports the
// first mismatching writeback (or a timeout) together with its index.
//
// state   | meaning
// IDLE    | waiting for start after reset
// ISSUE   | presenting mem[idx] to the core, waiting for core_ready
// WAIT_WB | instruction accepted, waiting for its expected writeback
// DONE    | run finished, result outputs valid until the next start
module instr_stream_checker
    import instr_chk_pkg::*;
#(
    parameter int XLEN    = CORE_XLEN,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [XLEN-1:0] prog_instr,
    input  logic            prog_chk,
    input  logic [4:0]      prog_reg,
    input  logic [XLEN-1:0] prog_val,
    input  logic [AW:0]     prog_len,
    input  logic            start,
    input  logic            core_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_reg,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] instruction,
    output logic            instr_valid,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [AW-1:0]   err_idx,
    output logic [XLEN-1:0] err_data,
    output logic [AW:0]     issued
);

    localparam int          TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_INIT = TW'(TIMEOUT - 1);
    localparam logic [AW:0] LEN_MAX    = (AW + 1)'(DEPTH);

    chk_state_t      state_q;
    logic [AW-1:0]   idx_q;
    logic [AW:0]     len_q;
    logic [TW-1:0]   timer_q;
    logic            instr_valid_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [AW-1:0]   err_idx_q;
    logic [XLEN-1:0] err_data_q;
    logic [AW:0]     issued_q;
    logic [AW:0]     issued_d;

    prog_entry_t wr_entry;
    prog_entry_t cur;
    logic        mem_we;
    logic        hs;
    logic        wb_hit;
    logic        data_ok;
    logic        len_ok;
    logic        last;

    // Programming is only honoured while no run is in flight.
    assign mem_we   = prog_we && (state_q == IDLE || state_q == DONE);
    assign wr_entry = '{instr: prog_instr, chk: prog_chk, rd: prog_reg, val: prog_val};

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (wr_entry),
        .raddr_i (idx_q),
        .rdata_o (cur)
    );

    assign hs       = instr_valid_q && core_ready;
    // A write to x0 can never satisfy an expectation, so expecting x0 times out.
    assign wb_hit   = wb_en && (wb_reg == cur.rd) && (wb_reg != REG_ZERO);
    assign data_ok  = (wb_data == cur.val);
    assign len_ok   = (prog_len != '0) && (prog_len <= LEN_MAX);
    assign last     = (({1'b0, idx_q} + 1'b1) == len_q);
    assign issued_d = (issued_q == LEN_MAX) ? issued_q : issued_q + 1'b1;

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            timer_q       <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_idx_q     <= '0;
            err_data_q    <= '0;
            issued_q      <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        idx_q      <= '0;
                        len_q      <= prog_len;
                        issued_q   <= '0;
                        pass_q     <= 1'b0;
                        err_idx_q  <= '0;
                        err_data_q <= '0;
                        if (len_ok) begin
                            state_q       <= ISSUE;
                            busy_q        <= 1'b1;
                            instr_valid_q <= 1'b1;
                            done_q        <= 1'b0;
                        end else begin
                            state_q       <= DONE;
                            busy_q        <= 1'b0;
                            instr_valid_q <= 1'b0;
                            done_q        <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        issued_q <= issued_d;
                        // The single-cycle core writes back in the accept cycle.
                        if (cur.chk && wb_hit && !data_ok) begin
                            state_q       <= DONE;
                            busy_q        <= 1'b0;
                            instr_valid_q <= 1'b0;
                            done_q        <= 1'b1;
                            pass_q        <= 1'b0;
                            err_idx_q     <= idx_q;
                            err_data_q    <= wb_data;
                        end else if (!cur.chk || wb_hit) begin
                            if (last) begin
                                state_q       <= DONE;
                                busy_q        <= 1'b0;
                                instr_valid_q <= 1'b0;
                                done_q        <= 1'b1;
                                pass_q        <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            state_q       <= WAIT_WB;
                            instr_valid_q <= 1'b0;
                            timer_q       <= TIMER_INIT;
                        end
                    end
                end
                WAIT_WB: begin
                    if (wb_hit && data_ok) begin
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q       <= ISSUE;
                            idx_q         <= idx_q + 1'b1;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (wb_hit || timer_q == '0) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        err_idx_q  <= idx_q;
                        err_data_q <= wb_hit ? wb_data : '0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instruction = instr_valid_q ? cur.instr : '0;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_idx     = err_idx_q;
    assign err_data    = err_data_q;
    assign issued      = issued_q;

endmodule

// File: tb/tb_instr_stream_checker.sv
// Scoreboard bench for instr_stream_checker: stimulus pushes expected issued
// words and run results; a negedge monitor pops and compares them.
module tb_instr_stream_checker;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic            clk;
    logic            nrst;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [XLEN-1:0] prog_instr;
    logic            prog_chk;
    logic [4:0]      prog_reg;
    logic [XLEN-1:0] prog_val;
    logic [AW:0]     prog_len;
    logic            start;
    logic            core_ready;
    logic            wb_en;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] instruction;
    logic            instr_valid;
    logic            busy;
    logic            done;
    logic            pass;
    logic [AW-1:0]   err_idx;
    logic [XLEN-1:0] err_data;
    logic [AW:0]     issued;

    instr_stream_checker #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_instr  (prog_instr),
        .prog_chk    (prog_chk),
        .prog_reg    (prog_reg),
        .prog_val    (prog_val),
        .prog_len    (prog_len),
        .start       (start),
        .core_ready  (core_ready),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_idx     (err_idx),
        .err_data    (err_data),
        .issued      (issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            pass;
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
        logic [AW:0]     issued;
    } res_t;

    logic [XLEN-1:0] exp_instr_q [$];
    res_t            exp_res_q [$];
    res_t            mon_r;
    int              n_tests = 0;
    int              n_fail  = 0;
    int              hold_cnt = 0;
    logic            done_prev = 1'b0;
    logic            start_prev = 1'b0;

    logic [31:0] P_INS [5] = '{32'h3e800093, 32'h83000113, 32'h3e906193, 32'h45707213, 32'h3f31f213};
    logic [4:0]  P_REG [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4};
    logic [31:0] P_VAL [5] = '{32'h000003E8, 32'hFFFFF830, 32'h000003E9, 32'h00000000, 32'h000003E1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Minimal single-cycle core: I-type addi/ori/andi, writeback in the accept cycle.
    logic [31:0] rf [32];
    logic        rf_clr;
    logic        core_wb_on;
    logic [31:0] imm;
    logic [31:0] rs1v;

    always_comb begin
        wb_en   = 1'b0;
        wb_reg  = '0;
        wb_data = '0;
        imm     = {{20{instruction[31]}}, instruction[31:20]};
        rs1v    = rf[instruction[19:15]];
        if (instr_valid && core_ready && core_wb_on && instruction[6:0] == 7'h13) begin
            wb_en  = 1'b1;
            wb_reg = instruction[11:7];
            case (instruction[14:12])
                3'b110:  wb_data = rs1v | imm;
                3'b111:  wb_data = rs1v & imm;
                default: wb_data = rs1v + imm;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_en && wb_reg != 5'd0) begin
            rf[wb_reg] <= wb_data;
        end
    end

    // Monitor: pops an expected word per handshake and a result per completed run.
    always @(negedge clk) begin
        if (!nrst) begin
            if (instr_valid && core_ready) begin
                if (exp_instr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL instr_unexpected: got 0x%0h, expected none", instruction);
                end else begin
                    check("instr", instruction, exp_instr_q.pop_front());
                end
            end
            if (instr_valid && instruction == 32'h83000113) hold_cnt++;
            if (done && (!done_prev || start_prev)) begin
                if (exp_res_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL result_unexpected: got pass=%0d, expected none", pass);
                end else begin
                    mon_r = exp_res_q.pop_front();
                    check("res_pass", pass, mon_r.pass);
                    check("res_err_idx", err_idx, mon_r.idx);
                    check("res_err_data", err_data, mon_r.data);
                    check("res_issued", issued, mon_r.issued);
                end
            end
        end
        done_prev  = done;
        start_prev = start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_res(input logic p, input int idx, input logic [31:0] d, input int iss);
        res_t r;
        r.pass   = p;
        r.idx    = AW'(idx);
        r.data   = d;
        r.issued = (AW + 1)'(iss);
        exp_res_q.push_back(r);
    endtask

    task automatic push_prog5();
        for (int i = 0; i < 5; i++) exp_instr_q.push_back(P_INS[i]);
    endtask

    task automatic load(input int a, input logic [31:0] ins, input logic c,
                        input logic [4:0] r, input logic [31:0] v);
        prog_we    = 1'b1;
        prog_addr  = AW'(a);
        prog_instr = ins;
        prog_chk   = c;
        prog_reg   = r;
        prog_val   = v;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic start_run(input int len);
        prog_len = (AW + 1)'(len);
        start    = 1'b1;
        rf_clr   = 1'b1;
        tick();
        start  = 1'b0;
        rf_clr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                tick();
                return;
            end
            tick();
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s_timeout: got busy=%0d, expected 0 within 200 cycles", name, busy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1);
    end

    int n_cyc;
    int h0;

    initial begin
        nrst       = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_instr = '0;
        prog_chk   = 1'b0;
        prog_reg   = '0;
        prog_val   = '0;
        prog_len   = '0;
        start      = 1'b0;
        core_ready = 1'b1;
        rf_clr     = 1'b0;
        core_wb_on = 1'b1;
        #1 nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instruction", instruction, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_idx", err_idx, 0);
        check("rst_err_data", err_data, 0);
        check("rst_issued", issued, 0);
        nrst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Five-entry program, all writebacks match.
        for (int i = 0; i < 5; i++) load(i, P_INS[i], 1'b1, P_REG[i], P_VAL[i]);
        push_prog5();
        push_res(1'b1, 0, 32'h0, 5);
        start_run(5);
        wait_idle("run_pass");

        // Entry 4 expects the wrong value.
        load(4, P_INS[4], 1'b1, 5'd4, 32'h000003E2);
        push_prog5();
        push_res(1'b0, 4, 32'h000003E1, 5);
        start_run(5);
        wait_idle("run_mismatch");

        // core_ready low for 3 cycles while entry 1 is presented.
        load(4, P_INS[4], 1'b1, 5'd4, 32'h000003E1);
        push_prog5();
        push_res(1'b1, 0, 32'h0, 5);
        h0 = hold_cnt;
        start_run(5);
        tick();
        core_ready = 1'b0;
        repeat (3) tick();
        core_ready = 1'b1;
        wait_idle("run_stall");
        check("stall_hold_cycles", hold_cnt - h0, 4);

        // Writeback never arrives.
        core_wb_on = 1'b0;
        exp_instr_q.push_back(P_INS[0]);
        push_res(1'b0, 0, 32'h0, 1);
        start_run(5);
        tick();
        n_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_cyc++;
            if (done) break;
        end
        check("timeout_cycles", n_cyc, 8);
        core_wb_on = 1'b1;
        wait_idle("run_timeout");

        // Reset while entry 2 is presented, then rerun.
        exp_instr_q.push_back(P_INS[0]);
        exp_instr_q.push_back(P_INS[1]);
        start_run(5);
        tick();
        tick();
        #1 nrst = 1'b1;
        #1;
        check("midrst_instr_valid", instr_valid, 0);
        check("midrst_instruction", instruction, 0);
        check("midrst_busy", busy, 0);
        check("midrst_issued", issued, 0);
        check("midrst_done", done, 0);
        @(posedge clk);
        #1 nrst = 1'b0;
        tick();
        push_prog5();
        push_res(1'b1, 0, 32'h0, 5);
        start_run(5);
        wait_idle("run_after_reset");

        // Out-of-range lengths go straight to DONE with pass=0.
        push_res(1'b0, 0, 32'h0, 0);
        start_run(0);
        check("len0_instr_valid", instr_valid, 0);
        check("len0_busy", busy, 0);
        check("len0_done", done, 1);
        tick();
        push_res(1'b0, 0, 32'h0, 0);
        start_run(DEPTH + 1);
        check("len17_busy", busy, 0);
        tick();

        // Full-depth run, no checks; entry 0 written in the same cycle as start.
        for (int i = 1; i < DEPTH; i++) load(i, 32'h00000013 | (32'(i) << 20), 1'b0, 5'd0, 32'h0);
        exp_instr_q.push_back(32'h7FF00013);
        for (int i = 1; i < DEPTH; i++) exp_instr_q.push_back(32'h00000013 | (32'(i) << 20));
        push_res(1'b1, 0, 32'h0, DEPTH);
        prog_we    = 1'b1;
        prog_addr  = '0;
        prog_instr = 32'h7FF00013;
        prog_chk   = 1'b0;
        prog_reg   = '0;
        prog_val   = '0;
        prog_len   = (AW + 1)'(DEPTH);
        start      = 1'b1;
        rf_clr     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        rf_clr  = 1'b0;
        n_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!instr_valid) break;
            n_cyc++;
            tick();
        end
        check("depth_valid_cycles", n_cyc, DEPTH);
        wait_idle("run_depth");

        repeat (2) tick();
        check("instr_queue_empty", exp_instr_q.size(), 0);
        check("result_queue_empty", exp_res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
